uart_receiver: RTL and testbench

- Oversampling UART receive engine; the serial-to-parallel counterpart of the UART transmitter.
- Synchronises the rx line, detects the start bit, and samples 5–8 data bits LSB-first.
- Checks optional parity and 1 or 2 stop bits.
- Delivers each frame with parity, framing, break and overrun flags over a valid/ready interface to the host-side consumer (register block or Rx monitor/scoreboard path).

---
 rtl/uart_receiver.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//
// Oversampling UART receive engine. It synchronises the serial line,
// qualifies the start bit and samples 5..8 data bits LSB-first. It then
// checks optional parity and one or two stop bits. Each finished frame is
// presented with its error flags on a valid/ready interface.
//
// Parameters
//   DATA_WIDTH    maximum data bits per frame (rxData width)
//   OVERSAMPLING  oversample ticks per bit, 16 or 13
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   rx              asynchronous serial input, idle high
//   baudDivisor     clk cycles per oversample tick (0 behaves as 1)
//   dataType        data bits per frame 5..8 (other values behave as 8)
//   parityEnable    parity bit present
//   parityType      0 = even, 1 = odd
//   stopBits        2 = two stop bits, anything else = one
//   rxData          received data, LSB-aligned, unused MSBs zero
//   rxValid/rxReady frame handshake toward the consumer
//   parityError     parity mismatch for rxData
//   framingError    a stop bit sampled low
//   breakError      data, parity and final stop all low
//   overrunError    an unaccepted frame was overwritten by this one
//   busy            receiver is inside a frame
//
// Build option
//   UART_RX_MAJORITY_VOTE_EN  when defined, each bit value is the 2-of-3
//   majority of the samples at SP-1, SP and SP+1. The decision moves to
//   SP+1. When undefined, each bit is a single sample at SP.
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned OVERSAMPLING = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  input  logic [15:0]           baudDivisor,
  input  logic [3:0]            dataType,
  input  logic                  parityEnable,
  input  logic                  parityType,
  input  logic [1:0]            stopBits,
  output logic [DATA_WIDTH-1:0] rxData,
  output logic                  rxValid,
  input  logic                  rxReady,
  output logic                  parityError,
  output logic                  framingError,
  output logic                  breakError,
  output logic                  overrunError,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [3:0] SC_LAST = 4'(OVERSAMPLING - 1);
  localparam logic [3:0] SP      = 4'(OVERSAMPLING / 2);

  // -------------------------------------------------------------------------
  // Input synchroniser (idle-high reset value keeps the line looking idle)
  // -------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // -------------------------------------------------------------------------
  // Oversample tick generator
  // -------------------------------------------------------------------------
  logic [15:0] div_cnt;
  logic [15:0] div_last;
  logic        tick;

  assign div_last = (baudDivisor == 16'd0) ? 16'd0 : baudDivisor - 16'd1;
  // >= rather than == so a count left above a freshly lowered divisor still wraps
  assign tick     = (div_cnt >= div_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Frame state
  // -------------------------------------------------------------------------
  state_t                state, state_nxt;
  logic [3:0]            sc, sc_nxt;
  logic [3:0]            bit_cnt, bit_cnt_nxt;
  logic                  stop_cnt, stop_cnt_nxt;
  logic                  armed, armed_nxt;
  logic [DATA_WIDTH-1:0] data_sh, data_nxt;
  logic                  par_bit, par_nxt;
  logic                  stop_err, stop_err_nxt;
  logic                  complete;

  // sc holds the in-bit index of the previous tick. idx is the index of the
  // tick being processed now. Bit boundaries and sample points are therefore
  // keyed on the actual tick count since the start edge was detected.
  logic [3:0] idx;
  logic       bit_end;
  logic       decide;
  logic       bit_val;
  logic [3:0] n_bits;
  logic [3:0] last_bit;
  logic       final_stop;

  assign idx     = (sc == SC_LAST) ? 4'd0 : sc + 4'd1;
  assign bit_end = (sc == SC_LAST);

  assign n_bits     = (dataType >= 4'd5 && dataType <= 4'd8) ? dataType : 4'd8;
  assign last_bit   = n_bits - 4'd1;
  assign final_stop = (stopBits == 2'd2) ? stop_cnt : 1'b1;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] SP_EARLY = SP - 4'd1;
  localparam logic [3:0] DECIDE   = SP + 4'd1;

  logic [1:0] vote_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vote_q <= '1;
    end else if (tick && state != IDLE) begin
      if (idx == SP_EARLY) vote_q[0] <= rx_s;
      if (idx == SP)       vote_q[1] <= rx_s;
    end
  end

  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
  assign decide  = (idx == DECIDE);
`else
  assign bit_val = rx_s;
  assign decide  = (idx == SP);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sc       <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      armed    <= 1'b0;
      data_sh  <= '0;
      par_bit  <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      sc       <= sc_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      armed    <= armed_nxt;
      data_sh  <= data_nxt;
      par_bit  <= par_nxt;
      stop_err <= stop_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    sc_nxt       = sc;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    armed_nxt    = armed;
    data_nxt     = data_sh;
    par_nxt      = par_bit;
    stop_err_nxt = stop_err;
    complete     = 1'b0;

    if (tick) begin
      case (state)
        IDLE: begin
          if (rx_s) begin
            armed_nxt = 1'b1;
          end else if (armed) begin
            state_nxt = START;
            sc_nxt    = '0;
            data_nxt  = '0;
          end
        end

        START: begin
          sc_nxt = idx;
          if (decide && bit_val) begin
            // false start: the line is already back high, so stay armed
            state_nxt = IDLE;
            sc_nxt    = '0;
          end else if (bit_end) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end
        end

        DATA: begin
          sc_nxt = idx;
          if (decide) begin
            for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
              if (bit_cnt == 4'(i)) data_nxt[i] = bit_val;
            end
          end
          if (bit_end) begin
            if (bit_cnt == last_bit) begin
              if (parityEnable) begin
                state_nxt = PARITY;
              end else begin
                state_nxt    = STOP;
                stop_cnt_nxt = 1'b0;
                stop_err_nxt = 1'b0;
              end
            end else begin
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end

        PARITY: begin
          sc_nxt = idx;
          if (decide) par_nxt = bit_val;
          if (bit_end) begin
            state_nxt    = STOP;
            stop_cnt_nxt = 1'b0;
            stop_err_nxt = 1'b0;
          end
        end

        STOP: begin
          sc_nxt = idx;
          if (decide) begin
            if (final_stop) begin
              // completion does not wait for the end of the stop bit
              complete  = 1'b1;
              state_nxt = IDLE;
              armed_nxt = 1'b0;
              sc_nxt    = '0;
            end else begin
              stop_err_nxt = ~bit_val;
            end
          end
          if (bit_end && !final_stop) stop_cnt_nxt = 1'b1;
        end

        default: begin
          state_nxt = IDLE;
          sc_nxt    = '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

  // -------------------------------------------------------------------------
  // Output holding register and handshake
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rxData       <= '0;
      rxValid      <= 1'b0;
      parityError  <= 1'b0;
      framingError <= 1'b0;
      breakError   <= 1'b0;
      overrunError <= 1'b0;
    end else if (complete) begin
      rxData       <= data_sh;
      parityError  <= parityEnable && ((^{data_sh, par_bit}) != parityType);
      framingError <= stop_err | ~bit_val;
      breakError   <= (data_sh == '0) && (!parityEnable || !par_bit) && !bit_val;
      // an accept in the same cycle retires the old frame cleanly
      overrunError <= rxValid && !rxReady;
      rxValid      <= 1'b1;
    end else if (rxValid && rxReady) begin
      rxValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int BIT_CLK = 32;  // baudDivisor 2 x 16 ticks

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [15:0] baudDivisor;
  logic [3:0]  dataType;
  logic        parityEnable;
  logic        parityType;
  logic [1:0]  stopBits;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic        parityError;
  logic        framingError;
  logic        breakError;
  logic        overrunError;
  logic        busy;

  uart_receiver #(.DATA_WIDTH(8), .OVERSAMPLING(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .baudDivisor  (baudDivisor),
    .dataType     (dataType),
    .parityEnable (parityEnable),
    .parityType   (parityType),
    .stopBits     (stopBits),
    .rxData       (rxData),
    .rxValid      (rxValid),
    .rxReady      (rxReady),
    .parityError  (parityError),
    .framingError (framingError),
    .breakError   (breakError),
    .overrunError (overrunError),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       p;
    logic       f;
    logic       b;
    logic       o;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     passed = 0;

  longint fall_t     = 0;
  longint rise_t     = 0;
  int     valid_len  = 0;
  int     last_len   = 0;
  logic   valid_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input bit par_en,
                            input bit par_b, input int nstop, input bit last_stop);
    rx = 1'b0;
    fall_t = $time;
    hold(BIT_CLK);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      hold(BIT_CLK);
    end
    if (par_en) begin
      rx = par_b;
      hold(BIT_CLK);
    end
    if (nstop == 2) begin
      rx = 1'b1;
      hold(BIT_CLK);
    end
    rx = last_stop;
    hold(BIT_CLK);
    rx = 1'b1;
    hold(BIT_CLK);
  endtask

  // Monitor: pops one expectation per accepted frame
  always @(negedge clk) begin
    frame_t act;
    frame_t e;
    if (reset) begin
      valid_prev = 1'b0;
      valid_len  = 0;
    end else begin
      if (rxValid && !valid_prev) rise_t = $time - 5;
      if (rxValid) valid_len++;
      else if (valid_prev) begin
        last_len  = valid_len;
        valid_len = 0;
      end
      if (rxValid && rxReady) begin
        act = {rxData, parityError, framingError, breakError, overrunError};
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_frame: got data=%h p%0d f%0d b%0d o%0d, required no frame",
                   act.data, act.p, act.f, act.b, act.o);
        end else begin
          e = exp_q.pop_front();
          if (act === e) passed++;
          else $display("FAIL frame: got data=%h p%0d f%0d b%0d o%0d, required data=%h p%0d f%0d b%0d o%0d",
                        act.data, act.p, act.f, act.b, act.o, e.data, e.p, e.f, e.b, e.o);
        end
      end
      valid_prev = rxValid;
    end
  end

  initial begin
    longint lat;
    logic [7:0] partial;

    reset        = 1'b1;
    rx           = 1'b1;
    baudDivisor  = 16'd2;
    dataType     = 4'd8;
    parityEnable = 1'b0;
    parityType   = 1'b0;
    stopBits     = 2'd1;
    rxReady      = 1'b1;
    hold(3);
    reset = 1'b0;
    check("reset_outputs",
          {rxData, rxValid, parityError, framingError, breakError, overrunError, busy}, '0);
    hold(2 * BIT_CLK);

    // 8N1 0xA5, latency and single-cycle valid
    exp_q.push_back('{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0});
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    lat = (rise_t - fall_t) / 10;
    checks++;
    if (lat >= 301 && lat <= 307) passed++;
    else $display("FAIL latency: got %0d clk, required 301..307", lat);
    check("valid_pulse_len", last_len, 1);

    // 7E1 0x3C with correct then wrong parity
    dataType     = 4'd7;
    parityEnable = 1'b1;
    parityType   = 1'b0;
    exp_q.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0});
    send_frame(8'h3C, 7, 1'b1, 1'b0, 1, 1'b1);
    exp_q.push_back('{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0});
    send_frame(8'h3C, 7, 1'b1, 1'b1, 1, 1'b1);

    // 8N2 0x81, second stop bit low
    dataType     = 4'd8;
    parityEnable = 1'b0;
    stopBits     = 2'd2;
    exp_q.push_back('{8'h81, 1'b0, 1'b1, 1'b0, 1'b0});
    send_frame(8'h81, 8, 1'b0, 1'b0, 2, 1'b0);
    stopBits = 2'd1;

    // break: line low for 20 bit times yields exactly one frame
    exp_q.push_back('{8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
    rx = 1'b0;
    hold(20 * BIT_CLK);
    check("break_no_retrigger_busy", busy, 0);
    rx = 1'b1;
    hold(3 * BIT_CLK);
    check("break_frame_consumed", exp_q.size(), 0);

    // overrun: 0x11 overwritten by 0x22 while consumer stalls
    rxReady = 1'b0;
    exp_q.push_back('{8'h22, 1'b0, 1'b0, 1'b0, 1'b1});
    send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
    check("valid_held_while_stalled", rxValid, 1);
    check("overrun_data", rxData, 8'h22);
    rxReady = 1'b1;
    hold(1);
    check("valid_drop_after_accept", rxValid, 0);

    // glitch: 3 ticks low is a false start
    rx = 1'b0;
    hold(5);
    check("glitch_busy_rises", busy, 1);
    hold(1);
    rx = 1'b1;
    hold(40);
    check("glitch_busy_idle", busy, 0);
    check("glitch_no_valid", rxValid, 0);

    // reset during data bit 4 discards the frame
    partial = 8'hFF;
    rx = 1'b0;
    hold(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      hold(BIT_CLK);
    end
    rx = partial[4];
    hold(16);
    check("busy_mid_frame", busy, 1);
    reset = 1'b1;
    hold(1);
    check("reset_mid_frame_outputs",
          {rxData, rxValid, parityError, framingError, breakError, overrunError, busy}, '0);
    reset = 1'b0;
    rx    = 1'b1;
    hold(2 * BIT_CLK);
    exp_q.push_back('{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0});
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);

    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
